// File: rtl/ctrl_pkg.sv
// Shared encodings for the single-cycle ARM-subset controller:
// instruction classes, ALU commands, condition codes and mux selects.
package ctrl_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_UND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;

endpackage

// File: rtl/cond_logic.sv
// Architectural NZCV register, condition evaluation, write-enable gating
// and the retired-instruction counter.
module cond_logic
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             pcs,
    output logic             reg_write,
    output logic             mem_write,
    output logic             pc_src,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] inst_ret
);

    logic n, z, c, v;
    logic cond_ex;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Reset suppresses every architectural write, even for an executing instruction.
    assign reg_write = reg_w & cond_ex & ~reset;
    assign mem_write = mem_w & cond_ex & ~reset;
    assign pc_src    = pcs   & cond_ex & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags    <= 4'b0000;
            inst_ret <= '0;
        end else begin
            if (flag_w[1] & cond_ex)
                flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] & cond_ex)
                flags[1:0] <= alu_flags[1:0];
            if (cond_ex)
                inst_ret <= inst_ret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/controller.sv
// Single-cycle ARM-subset control unit: combinational main/ALU decode
// feeding the condition logic that gates all architectural writes.
module controller
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0]      Instr,
    input  logic [3:0]       ALUFlags,
    output logic [1:0]       RegSrc,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic             ALUSrc,
    output logic [1:0]       ALUControl,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             PCSrc,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] InstRet
);

    logic [3:0] cond;
    op_t        op;
    logic [5:0] funct;
    logic [3:0] rd;

    logic       reg_w_main, reg_w, mem_w, branch, alu_op, cmd_ok, pcs;
    logic [1:0] flag_w;
    alu_ctrl_t  alu_ctrl;

    assign cond  = Instr[19:16];
    assign op    = op_t'(Instr[15:14]);
    assign funct = Instr[13:8];
    assign rd    = Instr[3:0];

    always_comb begin
        RegSrc     = REGSRC_DP;
        ImmSrc     = IMM_DP;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        reg_w_main = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (op)
            OP_DP: begin
                ALUSrc     = funct[5];
                reg_w_main = 1'b1;
                alu_op     = 1'b1;
            end
            OP_MEM: begin
                ImmSrc = IMM_MEM;
                ALUSrc = 1'b1;
                if (funct[0]) begin
                    MemtoReg   = 1'b1;
                    reg_w_main = 1'b1;
                end else begin
                    RegSrc = REGSRC_STR;
                    mem_w  = 1'b1;
                end
            end
            OP_BR: begin
                RegSrc = REGSRC_BR;
                ImmSrc = IMM_BR;
                ALUSrc = 1'b1;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Unsupported data-processing commands become harmless no-ops.
    always_comb begin
        alu_ctrl = ALU_ADD;
        cmd_ok   = 1'b1;
        if (alu_op) begin
            case (funct[4:1])
                CMD_ADD: alu_ctrl = ALU_ADD;
                CMD_SUB: alu_ctrl = ALU_SUB;
                CMD_AND: alu_ctrl = ALU_AND;
                CMD_ORR: alu_ctrl = ALU_ORR;
                default: cmd_ok   = 1'b0;
            endcase
        end
        flag_w[1] = alu_op & cmd_ok & funct[0];
        flag_w[0] = alu_op & cmd_ok & funct[0] &
                    ((alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SUB));
    end

    assign ALUControl = alu_ctrl;
    assign reg_w      = reg_w_main & cmd_ok;
    assign pcs        = branch | (reg_w & (rd == 4'hF));

    cond_logic #(
        .CNT_W(CNT_W)
    ) u_cond_logic (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .pcs       (pcs),
        .reg_write (RegWrite),
        .mem_write (MemWrite),
        .pc_src    (PCSrc),
        .flags     (Flags),
        .inst_ret  (InstRet)
    );

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: decode, condition gating, flag register
// update timing, reset behaviour and counter wrap on a narrow instance.
module tb_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;

    logic [1:0]  RegSrc, ImmSrc, ALUControl;
    logic        RegWrite, ALUSrc, MemtoReg, MemWrite, PCSrc;
    logic [3:0]  Flags;
    logic [31:0] InstRet;

    logic [1:0]  RegSrc4, ImmSrc4, ALUControl4;
    logic        RegWrite4, ALUSrc4, MemtoReg4, MemWrite4, PCSrc4;
    logic [3:0]  Flags4;
    logic [3:0]  InstRet4;

    int total = 0;
    int bad   = 0;

    controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .PCSrc(PCSrc), .Flags(Flags), .InstRet(InstRet)
    );

    controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .RegSrc(RegSrc4), .RegWrite(RegWrite4), .ImmSrc(ImmSrc4), .ALUSrc(ALUSrc4),
        .ALUControl(ALUControl4), .MemtoReg(MemtoReg4), .MemWrite(MemWrite4),
        .PCSrc(PCSrc4), .Flags(Flags4), .InstRet(InstRet4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; inputs change and outputs settle here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Instr = 20'hE5810; ALUFlags = 4'b0000;
        step(); step();
        total++; if (MemWrite !== 1'b0) begin bad++; $display("[TB] FAIL rst_memwrite got=%b want=0", MemWrite); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("[TB] FAIL rst_flags got=%b want=0000", Flags); end
        total++; if (InstRet !== 32'd0) begin bad++; $display("[TB] FAIL rst_instret got=%0d want=0", InstRet); end
        reset = 1'b0; #1;
        total++; if (MemWrite !== 1'b1) begin bad++; $display("[TB] FAIL rel_memwrite got=%b want=1", MemWrite); end
        step();
        total++; if (InstRet !== 32'd1) begin bad++; $display("[TB] FAIL rel_instret got=%0d want=1", InstRet); end
    endtask

    task automatic test_subs();
        Instr = 20'hE0510; ALUFlags = 4'b0110; #1;
        total++; if (ALUControl !== 2'b01) begin bad++; $display("[TB] FAIL subs_aluctl got=%b want=01", ALUControl); end
        total++; if (RegWrite !== 1'b1) begin bad++; $display("[TB] FAIL subs_regwrite got=%b want=1", RegWrite); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("[TB] FAIL subs_flags_early got=%b want=0000", Flags); end
        step();
        total++; if (Flags !== 4'b0110) begin bad++; $display("[TB] FAIL subs_flags got=%b want=0110", Flags); end
    endtask

    task automatic test_cond();
        Instr = 20'h00810; ALUFlags = 4'b1111; #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("[TB] FAIL addeq_regwrite got=%b want=1", RegWrite); end
        step();
        total++; if (InstRet !== 32'd3) begin bad++; $display("[TB] FAIL addeq_instret got=%0d want=3", InstRet); end
        total++; if (Flags !== 4'b0110) begin bad++; $display("[TB] FAIL addeq_flags got=%b want=0110", Flags); end
        Instr = 20'h10810; #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL addne_regwrite got=%b want=0", RegWrite); end
        total++; if (PCSrc !== 1'b0) begin bad++; $display("[TB] FAIL addne_pcsrc got=%b want=0", PCSrc); end
        step();
        total++; if (InstRet !== 32'd3) begin bad++; $display("[TB] FAIL addne_instret got=%0d want=3", InstRet); end
        total++; if (Flags !== 4'b0110) begin bad++; $display("[TB] FAIL addne_flags got=%b want=0110", Flags); end
    endtask

    task automatic test_flag_fields();
        Instr = 20'hE0112; ALUFlags = 4'b1011; #1;
        total++; if (ALUControl !== 2'b10) begin bad++; $display("[TB] FAIL ands_aluctl got=%b want=10", ALUControl); end
        step();
        total++; if (Flags !== 4'b1010) begin bad++; $display("[TB] FAIL ands_flags got=%b want=1010", Flags); end
        Instr = 20'hE1812; ALUFlags = 4'b0101; #1;
        total++; if (ALUControl !== 2'b11) begin bad++; $display("[TB] FAIL orr_aluctl got=%b want=11", ALUControl); end
        step();
        total++; if (Flags !== 4'b1010) begin bad++; $display("[TB] FAIL orr_flags got=%b want=1010", Flags); end
    endtask

    task automatic test_branch();
        Instr = 20'hEA000; ALUFlags = 4'b0000; #1;
        total++; if (PCSrc !== 1'b1) begin bad++; $display("[TB] FAIL b_pcsrc got=%b want=1", PCSrc); end
        total++; if (ImmSrc !== 2'b10) begin bad++; $display("[TB] FAIL b_immsrc got=%b want=10", ImmSrc); end
        total++; if (RegSrc !== 2'b01) begin bad++; $display("[TB] FAIL b_regsrc got=%b want=01", RegSrc); end
        total++; if (ALUSrc !== 1'b1) begin bad++; $display("[TB] FAIL b_alusrc got=%b want=1", ALUSrc); end
        total++; if (ALUControl !== 2'b00) begin bad++; $display("[TB] FAIL b_aluctl got=%b want=00", ALUControl); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL b_regwrite got=%b want=0", RegWrite); end
        step();
        Instr = 20'hE080F; #1;
        total++; if (PCSrc !== 1'b1) begin bad++; $display("[TB] FAIL addpc_pcsrc got=%b want=1", PCSrc); end
        total++; if (RegWrite !== 1'b1) begin bad++; $display("[TB] FAIL addpc_regwrite got=%b want=1", RegWrite); end
        step();
    endtask

    task automatic test_mem();
        Instr = 20'hE5910; #1;
        total++; if (MemtoReg !== 1'b1) begin bad++; $display("[TB] FAIL ldr_memtoreg got=%b want=1", MemtoReg); end
        total++; if (ImmSrc !== 2'b01) begin bad++; $display("[TB] FAIL ldr_immsrc got=%b want=01", ImmSrc); end
        total++; if (RegWrite !== 1'b1) begin bad++; $display("[TB] FAIL ldr_regwrite got=%b want=1", RegWrite); end
        total++; if (MemWrite !== 1'b0) begin bad++; $display("[TB] FAIL ldr_memwrite got=%b want=0", MemWrite); end
        step();
        Instr = 20'hE5810; #1;
        total++; if (RegSrc !== 2'b10) begin bad++; $display("[TB] FAIL str_regsrc got=%b want=10", RegSrc); end
        total++; if (MemWrite !== 1'b1) begin bad++; $display("[TB] FAIL str_memwrite got=%b want=1", MemWrite); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL str_regwrite got=%b want=0", RegWrite); end
        step();
    endtask

    task automatic test_no_write();
        Instr = 20'hE0212; #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL badcmd_regwrite got=%b want=0", RegWrite); end
        step();
        Instr = 20'hEC000; ALUFlags = 4'b0101; #1;
        total++; if ({RegWrite, MemWrite, PCSrc} !== 3'b000) begin bad++; $display("[TB] FAIL op11_writes got=%b want=000", {RegWrite, MemWrite, PCSrc}); end
        step();
        total++; if (Flags !== 4'b1010) begin bad++; $display("[TB] FAIL op11_flags got=%b want=1010", Flags); end
        Instr = 20'hF080F; #1;
        total++; if ({RegWrite, MemWrite, PCSrc} !== 3'b000) begin bad++; $display("[TB] FAIL nv_writes got=%b want=000", {RegWrite, MemWrite, PCSrc}); end
        step();
        total++; if (InstRet !== 32'd11) begin bad++; $display("[TB] FAIL nv_instret got=%0d want=11", InstRet); end
    endtask

    task automatic test_back_to_back();
        Instr = 20'h10510; ALUFlags = 4'b0100; #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("[TB] FAIL subsne_regwrite got=%b want=1", RegWrite); end
        step();
        total++; if (Flags !== 4'b0100) begin bad++; $display("[TB] FAIL subsne_flags got=%b want=0100", Flags); end
        Instr = 20'h10810; ALUFlags = 4'b0000; #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL next_ne_regwrite got=%b want=0", RegWrite); end
        step();
        Instr = 20'hA0810; #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("[TB] FAIL ge_regwrite got=%b want=1", RegWrite); end
        step();
        Instr = 20'hB0810; #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL lt_regwrite got=%b want=0", RegWrite); end
        step();
        Instr = 20'h80810; #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL hi_regwrite got=%b want=0", RegWrite); end
        step();
        total++; if (InstRet !== 32'd13) begin bad++; $display("[TB] FAIL b2b_instret got=%0d want=13", InstRet); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; Instr = 20'hE0510; ALUFlags = 4'b1111; #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("[TB] FAIL midrst_regwrite got=%b want=0", RegWrite); end
        step();
        total++; if (Flags !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_flags got=%b want=0000", Flags); end
        total++; if (InstRet !== 32'd0) begin bad++; $display("[TB] FAIL midrst_instret got=%0d want=0", InstRet); end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        Instr = 20'hE0800; ALUFlags = 4'b0000;
        for (int i = 0; i < 17; i++) step();
        total++; if (InstRet !== 32'd17) begin bad++; $display("[TB] FAIL wrap_instret32 got=%0d want=17", InstRet); end
        total++; if (InstRet4 !== 4'd1) begin bad++; $display("[TB] FAIL wrap_instret4 got=%0d want=1", InstRet4); end
    endtask

    initial begin
        test_reset();
        test_subs();
        test_cond();
        test_flag_fields();
        test_branch();
        test_mem();
        test_no_write();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Single-cycle ARM-subset control unit, directly upstream of the datapath.
- Decodes the upper instruction bits and drives the datapath control inputs: RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc.
- Also drives MemWrite to data memory.
- Holds the architectural NZCV flags register and evaluates the condition field each cycle.

Parameters:
- CNT_W, 32, width of retired-instruction counter InstRet.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- Instr  input  20  Instr[31:12] of the current instruction (cond, op, funct, Rd).
- ALUFlags  input  4  from datapath: [3]=N, [2]=Z, [1]=C, [0]=V.
- RegSrc  output  2  register read-address select.
- RegWrite  output  1  register file write enable (condition-gated).
- ImmSrc  output  2  extend-unit format select.
- ALUSrc  output  1  0=register SrcB, 1=ExtImm.
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- MemtoReg  output  1  result select, 1=ReadData.
- MemWrite  output  1  data-memory write enable (condition-gated).
- PCSrc  output  1  1=PC loads Result (condition-gated).
- Flags  output  4  current registered NZCV.
- InstRet  output  CNT_W  count of executed (CondEx=1) instructions.

Behaviour:
- Field extraction: Cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12].
- Main decode (combinational):
  - Op=00 data-processing: RegSrc=00, ALUSrc=Funct[5], ImmSrc=00, MemtoReg=0, RegW=1, MemW=0, Branch=0, ALUOp=1.
  - Op=01 with Funct[0]=1 (LDR): RegSrc=00, ImmSrc=01, ALUSrc=1, MemtoReg=1, RegW=1, MemW=0.
  - Op=01 with Funct[0]=0 (STR): RegSrc=10, ImmSrc=01, ALUSrc=1, MemtoReg=0, RegW=0, MemW=1.
  - Op=10 (B): RegSrc=01, ImmSrc=10, ALUSrc=1, MemtoReg=0, RegW=0, MemW=0, Branch=1, ALUOp=0.
  - Op=11 (undefined): all of RegW, MemW, Branch, FlagW are 0; other outputs 0.
- ALU decode:
  - ALUOp=0 -> ALUControl=00, FlagW=00.
  - ALUOp=1, cmd=Funct[4:1]: 0100 -> 00, 0010 -> 01, 0000 -> 10, 1100 -> 11.
  - Any other cmd: ALUControl=00, RegW forced 0, FlagW=00.
  - FlagW[1] (NZ) = Funct[0].
  - FlagW[0] (CV) = Funct[0] & (ALUControl is 00 or 01).
- PCS = Branch | (RegW & Rd==4'hF).
- Condition check on the registered flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 -> CondEx=0.
- Gating: RegWrite=RegW&CondEx, MemWrite=MemW&CondEx, PCSrc=PCS&CondEx.
- Flags register, on each rising edge:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1]&CondEx.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0]&CondEx.
  - Fields not enabled hold their value.
  - A flag update is visible to the next instruction's condition, never the setting instruction's own. Latency 1 cycle.
- InstRet increments by 1 on each edge with CondEx=1. Wraps modulo 2^CNT_W with no saturation.
- Reset:
  - On an edge with reset=1: Flags=0000 and InstRet=0.
  - While reset=1: RegWrite, MemWrite and PCSrc are forced 0, regardless of Instr.
  - Reset asserted mid-program discards any pending flag write that cycle.
- Control outputs are purely combinational from Instr and Flags; no extra pipeline stage.

Decomposition:
- Shared package (ctrl_pkg):
  - Op encodings (OP_DP, OP_MEM, OP_BR).
  - cmd encodings (CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR).
  - ALUControl encodings.
  - The 15 condition-code constants.
  - ImmSrc and RegSrc encodings.
- One sub-module, cond_logic:
  - Owns the flags register, the condition evaluator, the CondEx gating and InstRet.
  - The decoder stays combinational in the top module.

Test Plan:
- Reset: hold reset 2 cycles with Instr=STR AL -> MemWrite=0, Flags=0000, InstRet=0. Release -> MemWrite=1 next cycle.
- SUBS R0,R1,R1 (E0510001) with ALUFlags=0110 -> ALUControl=01, RegWrite=1. Next cycle Flags=0110.
- Then ADDEQ (00810002): CondEx=1, RegWrite=1. Then ADDNE (10810002): RegWrite=0, PCSrc=0, InstRet unchanged.
- ANDS with ALUFlags=1011 after Flags=0110 -> Flags=1010 (C,V retained). ORR without S -> Flags unchanged.
- B AL (EA000004): PCSrc=1, ImmSrc=10, RegSrc=01, ALUSrc=1, ALUControl=00. ADD Rd=15 AL -> PCSrc=1, RegWrite=1.
- Edge cases:
  - LDR (E5910000): MemtoReg=1, ImmSrc=01.
  - Op=11 or cond=1111: no writes.
  - CNT_W=4, 17 executed instructions: InstRet=1.
